// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  // Quotient reported on divide-by-zero; wider than any WIDTH so a cast truncates to all ones
  localparam logic [63:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract, keep or restore.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] trial;

  always_comb begin
    trial   = {rem_in, bit_in} - {1'b0, dvs};
    q_bit_c = ~trial[WIDTH];
    rem_c   = q_bit_c ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], bit_in};
  end

endmodule

// File: rtl/seq_divider16.sv
// Iterative radix-2 restoring divider with valid/ready handshakes, one quotient bit per clock.
// Define SEQ_DIVIDER16_SIGNED_EN for two's-complement operands (truncation toward zero).
module seq_divider16
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem_c;
  logic             step_bit_c;
  logic [WIDTH-1:0] q_next_c;
  logic [WIDTH-1:0] dividend_mag_c;
  logic [WIDTH-1:0] divisor_mag_c;
  logic             accept_c;
  logic             consume_c;

`ifdef SEQ_DIVIDER16_SIGNED_EN
  logic quot_neg_q, quot_neg_d;
  logic rem_neg_q, rem_neg_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_q),
    .bit_in  (q_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_c   (step_rem_c),
    .q_bit_c (step_bit_c)
  );

  // Next state, datapath and registered outputs
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER16_SIGNED_EN
    quot_neg_d  = quot_neg_q;
    rem_neg_d   = rem_neg_q;
    dividend_mag_c = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    divisor_mag_c  = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
`else
    dividend_mag_c = dividend;
    divisor_mag_c  = divisor;
`endif
    q_next_c  = {q_q[WIDTH-2:0], step_bit_c};
    accept_c  = in_valid && in_ready_q;
    consume_c = out_valid_q && out_ready;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = WIDTH'(DBZ_QUOT);
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = '0;
            q_d     = dividend_mag_c;
            dvs_d   = divisor_mag_c;
            cnt_d   = CNT_W'(WIDTH);
            dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER16_SIGNED_EN
            quot_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg_d  = dividend[WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        r_d   = step_rem_c;
        q_d   = q_next_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
`ifdef SEQ_DIVIDER16_SIGNED_EN
          quotient_d  = quot_neg_q ? (~q_next_c + WIDTH'(1)) : q_next_c;
          remainder_d = rem_neg_q ? (~step_rem_c + WIDTH'(1)) : step_rem_c;
`else
          quotient_d  = q_next_c;
          remainder_d = step_rem_c;
`endif
        end
      end
      DONE: begin
        // Result registers settle on entry; valid is raised one cycle later
        out_valid_d = 1'b1;
        if (consume_c) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER16_SIGNED_EN
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef SEQ_DIVIDER16_SIGNED_EN
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider16.md
Name: seq_divider16

Overview:
- Iterative radix-2 restoring divider; the inverse operation of the MAC-path Wallace multiplier.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Sits beside the multiplier in the MAC datapath. Uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider can accept operands (high only in IDLE).
- dividend  input  WIDTH  numerator, sampled on accept.
- divisor  input  WIDTH  denominator, sampled on accept.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  the result came from divisor == 0.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-low (rst_n), sampled on the clk rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Accept: an operand is taken when in_valid && in_ready. The operands are latched and in_ready drops on the next cycle.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on accept with divisor != 0.
  - Load: partial remainder R=0, Q=dividend, D=divisor, counter=WIDTH.
- IDLE -> DONE on accept with divisor == 0. Bypass result:
  - quotient = all ones.
  - remainder = dividend.
  - div_by_zero = 1.
- CALC, each cycle:
  - Form a WIDTH+1-bit trial T = {R, Q[MSB]} - {1'b0, D}.
  - If T is non-negative: R = T[WIDTH-1:0] and shift 1 into Q.
  - Otherwise: R = {R, Q[MSB]} truncated to WIDTH bits, and shift 0 into Q.
  - Decrement the counter. When the counter reaches 1, go to DONE.
- CALC lasts exactly WIDTH cycles.
- Latency: accept at edge N; out_valid=1 after edge N+WIDTH+1 (17 cycles for WIDTH=16). The divide-by-zero path takes 1 cycle.
- DONE:
  - out_valid=1. quotient, remainder and div_by_zero stay stable until out_valid && out_ready.
  - On that edge: DONE -> IDLE, out_valid=0, in_ready=1.
- No new operand is accepted in the cycle the result is consumed; the next accept is possible one cycle later.
- Backpressure: if out_ready is low, DONE holds indefinitely and in_valid is ignored.
- Reset mid-operation: rst_n low on any edge aborts the calculation and restores all reset values. No partial result is ever presented.
- Inputs dividend and divisor are don't-care outside the accept cycle.
- div_by_zero clears on the next accepted non-zero divide. It holds its value while out_valid is low.

Optional Feature:
- Macro: SEQ_DIVIDER16_SIGNED_EN.
- Defined: operands are two's complement.
  - The core divides magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign (truncation toward zero).
  - Sign fix-up is registered on the CALC->DONE edge, so latency is unchanged.
  - Overflow case (-2^(WIDTH-1) / -1): quotient = 0x8000, remainder = 0.
  - Divide-by-zero: quotient = all ones (-1), remainder = dividend.
- Undefined: pure unsigned operation with no sign logic.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - a default-width constant (16);
  - the divide-by-zero quotient constant (all ones).
- Sub-module div_step: one combinational restoring step.
  - Inputs: R, next bit, D.
  - Outputs: new R and quotient bit.
  - Instantiated once inside seq_divider16; it is the only natural split.

Test Plan:
- 100 / 7 unsigned -> after 17 cycles out_valid=1, quotient=14, remainder=2, div_by_zero=0.
- 0xFFFF / 0x0001, then 0x1234 / 0xFFFF -> quotient=0xFFFF, rem=0; then quotient=0, rem=0x1234.
- 0x00AB / 0 -> out_valid after 1 cycle, quotient=0xFFFF, remainder=0x00AB, div_by_zero=1. The next divide 9/3 gives quotient 3, div_by_zero=0.
- Backpressure and handshake:
  - Hold out_ready=0 for 10 cycles after DONE -> outputs stable, in_ready=0, extra in_valid ignored.
  - Raise out_ready -> in_ready=1 on the following cycle.
- Drive rst_n=0 at cycle 8 of CALC -> next cycle: IDLE, out_valid=0, quotient=0, in_ready=1. A fresh 50/5 then returns 10 r 0.
- With SEQ_DIVIDER16_SIGNED_EN:
  - -7/2 -> q=-3 (0xFFFD), r=-1.
  - 7/-2 -> q=-3, r=1.
  - 0x8000/0xFFFF -> q=0x8000, r=0.
